// File: rtl/merge_pkg.sv
// Shared widths, selection encoding and key compare helpers for the two-way merge core.
package merge_pkg;

    localparam int DATA_W = 128;
    localparam int KEY_W  = 80;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2,
        SEL_TERM = 2'd3
    } sel_e;

    typedef struct packed {
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
    } pair_t;

    function automatic logic key_le(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        return a <= b;
    endfunction

    // Key-only compare/exchange; on equal keys the first operand lands in lo.
    function automatic pair_t cmpx(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        pair_t r;
        if (key_le(a[KEY_W-1:0], b[KEY_W-1:0])) begin
            r.lo = a;
            r.hi = b;
        end else begin
            r.lo = b;
            r.hi = a;
        end
        return r;
    endfunction

endpackage

// File: rtl/ififo16.sv
// 16-entry show-ahead FIFO: the head entry is visible combinationally while not empty.
module ififo16 #(
    parameter int P_WIDTH = 128
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [P_WIDTH-1:0] i_data,
    input  logic               i_enq,
    input  logic               i_deq,
    output logic [P_WIDTH-1:0] o_data,
    output logic               o_empty,
    output logic               o_full
);

    logic [P_WIDTH-1:0] r_mem [16];
    logic [3:0]         r_wr_ptr;
    logic [3:0]         r_rd_ptr;
    logic [4:0]         r_count;
    logic               w_push;
    logic               w_pop;

    assign o_empty = (r_count == 5'd0);
    assign o_full  = (r_count == 5'd16);
    assign w_push  = i_enq & ~o_full;
    assign w_pop   = i_deq & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // NOTE: the storage array is deliberately not reset; empty/full come from the
    // count alone, so stale contents are never observed and the RAM can map to flops or LUTRAM.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 4'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 4'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/merge_core.sv
// Two-way streaming merge: input FIFOs, head selection and a two-stage compare/exchange
// pipeline that reproduces the selection order with a fixed 3-cycle latency.
module merge_core
    import merge_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int KEY_WIDTH  = KEY_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    input  logic                  i_a_valid,
    output logic                  o_a_ready,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    input  logic                  i_b_valid,
    output logic                  o_b_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_out_ready
);

    logic [DATA_WIDTH-1:0] w_a_head;
    logic [DATA_WIDTH-1:0] w_b_head;
    logic                  w_a_empty;
    logic                  w_b_empty;
    logic                  w_a_full;
    logic                  w_b_full;
    logic                  w_a_zero;
    logic                  w_b_zero;
    logic                  w_stall;
    logic                  w_pop_a;
    logic                  w_pop_b;
    logic                  w_switch;
    logic [DATA_WIDTH-1:0] w_pick;
    logic [DATA_WIDTH-1:0] w_hi1;
    sel_e                  w_sel;
    pair_t                 w_cx2;

    // selection registers
    logic [DATA_WIDTH-1:0] r_ra;
    logic [DATA_WIDTH-1:0] r_rb;
    logic [DATA_WIDTH-1:0] r_top;
    logic                  r_sw0;
    logic                  r_v0;
    // stage 1
    logic [DATA_WIDTH-1:0] r_hi1;
    logic [DATA_WIDTH-1:0] r_top1;
    logic                  r_sw1;
    logic                  r_v1;

    ififo16 #(.P_WIDTH(DATA_WIDTH)) u_fifo_a (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_data  (i_a_data),
        .i_enq   (i_a_valid & o_a_ready),
        .i_deq   (w_pop_a),
        .o_data  (w_a_head),
        .o_empty (w_a_empty),
        .o_full  (w_a_full)
    );

    ififo16 #(.P_WIDTH(DATA_WIDTH)) u_fifo_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_data  (i_b_data),
        .i_enq   (i_b_valid & o_b_ready),
        .i_deq   (w_pop_b),
        .o_data  (w_b_head),
        .o_empty (w_b_empty),
        .o_full  (w_b_full)
    );

    assign o_a_ready = ~w_a_full;
    assign o_b_ready = ~w_b_full;

    assign w_a_zero = (w_a_head == '0);
    assign w_b_zero = (w_b_head == '0);
    assign w_stall  = w_a_empty | w_b_empty | ~i_out_ready;

    always_comb begin
        w_sel = SEL_NONE;
        if (!w_stall) begin
            if (w_a_zero && w_b_zero) begin
                w_sel = SEL_TERM;
            end else if (w_b_zero || (!w_a_zero &&
                         key_le(w_a_head[KEY_WIDTH-1:0], w_b_head[KEY_WIDTH-1:0]))) begin
                w_sel = SEL_A;
            end else begin
                w_sel = SEL_B;
            end
        end
    end

    assign w_pop_a  = (w_sel == SEL_A) || (w_sel == SEL_TERM);
    assign w_pop_b  = (w_sel == SEL_B) || (w_sel == SEL_TERM);
    assign w_switch = (w_sel == SEL_A) || (w_sel == SEL_B);
    assign w_pick   = (w_sel == SEL_A) ? w_a_head :
                      (w_sel == SEL_B) ? w_b_head : '0;

    // Only the high half of the stage-1 exchange feeds stage 2.
    assign w_hi1 = key_le(r_ra[KEY_WIDTH-1:0], r_rb[KEY_WIDTH-1:0]) ? r_rb : r_ra;
    assign w_cx2 = cmpx(r_top1, r_hi1);

    // The whole pipeline advances on i_out_ready alone, so a stalled consumer
    // freezes every stage and o_data/o_valid together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ra    <= '0;
            r_rb    <= '0;
            r_top   <= '0;
            r_sw0   <= 1'b0;
            r_v0    <= 1'b0;
            r_hi1   <= '0;
            r_top1  <= '0;
            r_sw1   <= 1'b0;
            r_v1    <= 1'b0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else if (i_out_ready) begin
            if (w_sel != SEL_NONE) begin
                if (w_sel == SEL_A || w_sel == SEL_TERM) begin
                    r_ra <= w_pick;
                end
                if (w_sel == SEL_B || w_sel == SEL_TERM) begin
                    r_rb <= w_pick;
                end
                r_top <= w_pick;
                r_sw0 <= w_switch;
                r_v0  <= 1'b1;
            end else begin
                r_v0  <= 1'b0;
            end

            r_hi1  <= w_hi1;
            r_top1 <= r_top;
            r_sw1  <= r_sw0;
            r_v1   <= r_v0;

            o_data  <= r_sw1 ? w_cx2.hi : w_cx2.lo;
            o_valid <= r_v1;
        end
    end

endmodule

// File: tb/tb_merge_core.sv
// Directed bench for merge_core: a queue-level merge model scores every accepted output,
// and each scenario's captured sequence is also compared with a hand-written expectation.
module tb_merge_core;

    typedef logic [127:0] rec_t;
    typedef rec_t rec_q_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    rec_t a_data = '0;
    logic a_valid = 1'b0;
    logic o_a_ready;
    rec_t b_data = '0;
    logic b_valid = 1'b0;
    logic o_b_ready;
    rec_t o_data;
    logic o_valid;
    logic out_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    int   cyc = 0;
    rec_q_t mq_a, mq_b, got;
    int   n_out = 0;
    int   first_a = -1, first_b = -1, first_valid = -1, last_out = -1;
    logic prev_hold = 1'b0;
    rec_t held_data = '0;

    merge_core dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_a_data    (a_data),
        .i_a_valid   (a_valid),
        .o_a_ready   (o_a_ready),
        .i_b_data    (b_data),
        .i_b_valid   (b_valid),
        .o_b_ready   (o_b_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input rec_t act, input rec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, i.e. the values the next rising edge will act on.
    always @(negedge clk) begin
        rec_t ha, hb, exp;
        if (!rst) begin
            if (prev_hold) begin
                check("hold_valid", rec_t'(o_valid), 1);
                check("hold_data", o_data, held_data);
            end
            if (o_valid && out_ready) begin
                if (mq_a.size() == 0 || mq_b.size() == 0) begin
                    check("unexpected_output", rec_t'(o_valid), 0);
                end else begin
                    ha = mq_a[0];
                    hb = mq_b[0];
                    if (ha == '0 && hb == '0) begin
                        exp = '0;
                        void'(mq_a.pop_front());
                        void'(mq_b.pop_front());
                    end else if (hb == '0 || (ha != '0 && ha[79:0] <= hb[79:0])) begin
                        exp = mq_a.pop_front();
                    end else begin
                        exp = mq_b.pop_front();
                    end
                    check("merge_out", o_data, exp);
                end
                got.push_back(o_data);
                if (n_out == 0) first_valid = cyc;
                last_out = cyc;
                n_out++;
            end
            prev_hold = o_valid && !out_ready;
            held_data = o_data;
            if (a_valid && o_a_ready) begin
                mq_a.push_back(a_data);
                if (first_a < 0) first_a = cyc;
            end
            if (b_valid && o_b_ready) begin
                mq_b.push_back(b_data);
                if (first_b < 0) first_b = cyc;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        out_ready = 1'b1;
        mq_a.delete();
        mq_b.delete();
        got.delete();
        n_out = 0;
        first_a = -1;
        first_b = -1;
        first_valid = -1;
        last_out = -1;
        prev_hold = 1'b0;
        #2;
        check("rst_o_valid", rec_t'(o_valid), 0);
        check("rst_o_data", o_data, '0);
        check("rst_a_ready", rec_t'(o_a_ready), 1);
        check("rst_b_ready", rec_t'(o_b_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic feed_a(input rec_q_t recs);
        foreach (recs[i]) begin
            int budget;
            budget = 0;
            a_valid = 1'b1;
            a_data  = recs[i];
            @(negedge clk);
            while (!o_a_ready && budget < 200) begin
                budget++;
                @(negedge clk);
            end
            if (!o_a_ready) check("a_push_timeout", rec_t'(o_a_ready), 1);
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0;
        a_data  = '0;
    endtask

    task automatic feed_b(input rec_q_t recs);
        foreach (recs[i]) begin
            int budget;
            budget = 0;
            b_valid = 1'b1;
            b_data  = recs[i];
            @(negedge clk);
            while (!o_b_ready && budget < 200) begin
                budget++;
                @(negedge clk);
            end
            if (!o_b_ready) check("b_push_timeout", rec_t'(o_b_ready), 1);
            @(posedge clk);
            #1;
        end
        b_valid = 1'b0;
        b_data  = '0;
    endtask

    // Waits (bounded) for the expected count, idles to catch extras, then compares literally.
    task automatic expect_seq(input string name, input rec_q_t exp);
        int budget;
        budget = 0;
        while (n_out < exp.size() && budget < 400) begin
            @(posedge clk);
            #1;
            budget++;
        end
        repeat (6) @(posedge clk);
        #1;
        check({name, "_count"}, n_out, exp.size());
        foreach (exp[i]) begin
            if (i < got.size()) check({name, "_seq"}, got[i], exp[i]);
        end
        check({name, "_qa_left"}, mq_a.size(), 0);
        check({name, "_qb_left"}, mq_b.size(), 0);
        check({name, "_idle_valid"}, rec_t'(o_valid), 0);
    endtask

    initial begin
        rec_q_t qa, qb, ex;
        int budget;

        // Reset, then A alone must never produce output.
        do_reset();
        qa = '{128'h11};
        feed_a(qa);
        repeat (10) @(posedge clk);
        #1;
        check("a_only_count", n_out, 0);
        check("a_only_valid", rec_t'(o_valid), 0);

        // Basic merge with latency and throughput.
        do_reset();
        qa = '{128'd1, 128'd3, 128'd5, 128'd0};
        qb = '{128'd2, 128'd4, 128'd6, 128'd0};
        fork
            feed_a(qa);
            feed_b(qb);
        join
        ex = '{128'd1, 128'd2, 128'd3, 128'd4, 128'd5, 128'd6, 128'd0};
        expect_seq("basic", ex);
        check("basic_latency", first_valid - ((first_a > first_b) ? first_a : first_b) - 1, 3);
        check("basic_back_to_back", last_out - first_valid, 6);

        // Equal keys: A first, payload distinguishes the two records.
        do_reset();
        qa = '{(128'hA << 80) | 128'd7, 128'd0};
        qb = '{(128'hB << 80) | 128'd7, 128'd0};
        fork
            feed_a(qa);
            feed_b(qb);
        join
        ex = '{(128'hA << 80) | 128'd7, (128'hB << 80) | 128'd7, 128'd0};
        expect_seq("tie", ex);

        // Consumer backpressure for 5 cycles mid-stream.
        do_reset();
        qa = '{128'd10, 128'd30, 128'd50, 128'd70, 128'd0};
        qb = '{128'd20, 128'd40, 128'd60, 128'd80, 128'd0};
        fork
            feed_a(qa);
            feed_b(qb);
            begin
                budget = 0;
                while (n_out < 3 && budget < 200) begin
                    @(posedge clk);
                    #1;
                    budget++;
                end
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        ex = '{128'd10, 128'd20, 128'd30, 128'd40, 128'd50, 128'd60, 128'd70, 128'd80, 128'd0};
        expect_seq("backpressure", ex);

        // Fill FIFO A completely while B is empty, then let B drain it.
        do_reset();
        qa.delete();
        for (int i = 1; i <= 16; i++) qa.push_back(rec_t'(i));
        feed_a(qa);
        check("full_a_ready", rec_t'(o_a_ready), 0);
        repeat (5) @(posedge clk);
        #1;
        check("full_no_output", n_out, 0);
        check("full_valid_low", rec_t'(o_valid), 0);
        qa = '{128'd0};
        qb = '{128'd100, 128'd0};
        fork
            feed_a(qa);
            feed_b(qb);
        join
        ex.delete();
        for (int i = 1; i <= 16; i++) ex.push_back(rec_t'(i));
        ex.push_back(128'd100);
        ex.push_back(128'd0);
        expect_seq("fifo_full", ex);

        // Uneven runs, including an empty first run on A.
        do_reset();
        qa = '{128'd0, 128'd4, 128'd0};
        qb = '{128'd5, 128'd9, 128'd0, 128'd3, 128'd0};
        fork
            feed_a(qa);
            feed_b(qb);
        join
        ex = '{128'd5, 128'd9, 128'd0, 128'd3, 128'd4, 128'd0};
        expect_seq("uneven", ex);

        // Reset mid-stream drops everything queued and in flight.
        do_reset();
        qa = '{128'd1, 128'd0};
        qb = '{128'd2, 128'd0};
        fork
            feed_a(qa);
            feed_b(qb);
        join
        budget = 0;
        while (n_out < 1 && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("midrst_first_out", n_out, 1);
        do_reset();
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_output", n_out, 0);
        check("midrst_valid", rec_t'(o_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
